// File: rtl/ht_res_sink_pkg.sv
// ---------------------------------------------------------------------------
// ht_res_sink_pkg
// Shared types for the hash-table result path: command opcodes, result codes,
// the result record carried on ht_res_if, and the statistics counter
// selector/hit types used by the result sink.
//
// Contents:
//   ht_opcode_t       : INIT / SEARCH / INSERT / DELETE
//   ht_rescode_t      : per-operation outcome codes
//   ht_cmd_t          : opcode + key + value
//   ht_result_t       : command echo + result code
//   ht_stat_sel_t     : statistics counter index
//   ht_stat_hit_t     : one increment request bit per statistics counter
//   is_fail_rescode() : membership test for the not-success codes
//   opcode_stat_sel() : opcode -> statistics counter index
// ---------------------------------------------------------------------------
package ht_res_sink_pkg;

  localparam int KEY_W     = 16;
  localparam int VALUE_W   = 16;
  localparam int NUM_STATS = 5;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_SEARCH = 2'd1,
    OP_INSERT = 2'd2,
    OP_DELETE = 2'd3
  } ht_opcode_t;

  typedef enum logic [2:0] {
    INIT_SUCCESS                     = 3'd0,
    SEARCH_FOUND                     = 3'd1,
    SEARCH_NOT_SUCCESS_NO_ENTRY      = 3'd2,
    INSERT_SUCCESS                   = 3'd3,
    INSERT_SUCCESS_SAME_KEY          = 3'd4,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL = 3'd5,
    DELETE_SUCCESS                   = 3'd6,
    DELETE_NOT_SUCCESS_NO_ENTRY      = 3'd7
  } ht_rescode_t;

  typedef struct packed {
    ht_opcode_t           opcode;
    logic [KEY_W-1:0]     key;
    logic [VALUE_W-1:0]   value;
  } ht_cmd_t;

  typedef struct packed {
    ht_cmd_t     cmd;
    ht_rescode_t rescode;
  } ht_result_t;

  // Statistics counter index; the four opcode counters come first so that
  // opcode_stat_sel() is a direct mapping.
  typedef enum logic [2:0] {
    STAT_INIT   = 3'd0,
    STAT_SEARCH = 3'd1,
    STAT_INSERT = 3'd2,
    STAT_DELETE = 3'd3,
    STAT_FAIL   = 3'd4
  } ht_stat_sel_t;

  typedef logic [NUM_STATS-1:0] ht_stat_hit_t;

  function automatic logic is_fail_rescode(input ht_rescode_t rc);
    case (rc)
      SEARCH_NOT_SUCCESS_NO_ENTRY,
      INSERT_NOT_SUCCESS_TABLE_IS_FULL,
      DELETE_NOT_SUCCESS_NO_ENTRY: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic ht_stat_sel_t opcode_stat_sel(input ht_opcode_t op);
    case (op)
      OP_INIT:   return STAT_INIT;
      OP_SEARCH: return STAT_SEARCH;
      OP_INSERT: return STAT_INSERT;
      OP_DELETE: return STAT_DELETE;
      default:   return STAT_INIT;
    endcase
  endfunction

endpackage

// File: rtl/ht_res_if.sv
// ---------------------------------------------------------------------------
// ht_res_if
// Valid/ready stream carrying one ht_result_t per transfer.
//
// Signals:
//   valid  : producer has a result on 'result'
//   result : hash-table result record
//   ready  : consumer can take a result this cycle
// Modports: master (producer), slave (consumer).
// ---------------------------------------------------------------------------
interface ht_res_if;
  import ht_res_sink_pkg::*;

  logic       valid;
  ht_result_t result;
  logic       ready;

  modport master (output valid, output result, input  ready);
  modport slave  (input  valid, input  result, output ready);

endinterface

// File: rtl/ht_res_sink_fifo.sv
// ---------------------------------------------------------------------------
// ht_res_sink_fifo
// Show-ahead FIFO of ht_result_t entries. The head entry is presented on
// rd_data_o whenever rd_valid_o is high; a write into an empty FIFO becomes
// visible one cycle later (no fall-through path).
//
// Parameters:
//   DEPTH       : number of entries, power of two, >= 2
// Ports:
//   clk_i       : clock, rising edge
//   rst_n_i     : asynchronous active-low reset
//   wr_en_i     : write request (taken only while wr_ready_o is high)
//   wr_data_i   : entry to write
//   wr_ready_o  : registered "not full" indication, low during reset
//   rd_en_i     : pop request (ignored while empty)
//   rd_valid_o  : FIFO not empty
//   rd_data_o   : head entry
//   used_o      : occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ht_res_sink_fifo
  import ht_res_sink_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     wr_en_i,
  input  ht_result_t               wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output ht_result_t               rd_data_o,
  output logic [$clog2(DEPTH):0]   used_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   USED_ONE  = UW'(1);
  localparam logic [AW:0]   DEPTH_CNT = UW'(DEPTH);

  // Storage holds data only, so it carries no reset.
  ht_result_t    mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   used_q,   used_d;
  logic          wr_ready_q, wr_ready_d;
  logic          push, pop;

  // Both qualifiers come from registered state only, so a pop in the same
  // cycle cannot open the write side of a full FIFO.
  assign push = wr_en_i && wr_ready_q;
  assign pop  = rd_en_i && (used_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;

    // Power-of-two depth: pointers wrap by natural overflow.
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   used_d = used_q + USED_ONE;
      2'b01:   used_d = used_q - USED_ONE;
      default: used_d = used_q;
    endcase

    // Registered ready: low while in reset, rises on the first edge after
    // release, and otherwise tracks "occupancy below DEPTH".
    wr_ready_d = (used_d != DEPTH_CNT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign wr_ready_o = wr_ready_q;
  assign rd_valid_o = (used_q != '0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign used_o     = used_q;

endmodule

// File: rtl/ht_res_sink.sv
// ---------------------------------------------------------------------------
// ht_res_sink
// Terminates the hash-table result stream: buffers results in a show-ahead
// FIFO for a downstream reader and (optionally) keeps saturating statistics
// counters of accepted results.
//
// Build option:
//   HT_RES_SINK_STATS_EN : when defined, the statistics counters are built.
//                          When undefined, every cnt_*_o is tied to 0 and
//                          clear_stats_i has no effect.
//
// Parameters:
//   FIFO_DEPTH    : result buffer depth (power of two, >= 2)
//   CNT_WIDTH     : width of each statistics counter
// Ports:
//   clk_i         : clock, rising edge
//   rst_n_i       : asynchronous active-low reset
//   ht_res_in     : result stream (slave): valid, result, ready
//   rd_en_i       : pop request from the reader
//   rd_valid_o    : head entry valid
//   rd_data_o     : head entry (show-ahead)
//   used_o        : occupancy
//   clear_stats_i : synchronous clear of all counters
//   cnt_init_o / cnt_search_o / cnt_insert_o / cnt_delete_o
//                 : accepted results per opcode
//   cnt_fail_o    : accepted results with a not-success result code
// ---------------------------------------------------------------------------
module ht_res_sink
  import ht_res_sink_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  ht_res_if.slave                       ht_res_in,
  input  logic                          rd_en_i,
  output logic                          rd_valid_o,
  output ht_result_t                    rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]   used_o,
  input  logic                          clear_stats_i,
  output logic [CNT_WIDTH-1:0]          cnt_init_o,
  output logic [CNT_WIDTH-1:0]          cnt_search_o,
  output logic [CNT_WIDTH-1:0]          cnt_insert_o,
  output logic [CNT_WIDTH-1:0]          cnt_delete_o,
  output logic [CNT_WIDTH-1:0]          cnt_fail_o
);

  logic wr_ready;

  ht_res_sink_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wr_en_i    (ht_res_in.valid),
    .wr_data_i  (ht_res_in.result),
    .wr_ready_o (wr_ready),
    .rd_en_i    (rd_en_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .used_o     (used_o)
  );

  assign ht_res_in.ready = wr_ready;

`ifdef HT_RES_SINK_STATS_EN

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);

  // Saturating increment: an all-ones counter stays put.
  function automatic cnt_t sat_inc(input cnt_t v);
    if (&v) return v;
    return v + CNT_ONE;
  endfunction

  logic         accept;
  ht_stat_hit_t hit;
  cnt_t         cnt_q [NUM_STATS];
  cnt_t         cnt_d [NUM_STATS];

  assign accept = ht_res_in.valid && wr_ready;

  always_comb begin
    hit = '0;
    if (accept) begin
      hit[opcode_stat_sel(ht_res_in.result.cmd.opcode)] = 1'b1;
      hit[STAT_FAIL] = is_fail_rescode(ht_res_in.result.rescode);
    end

    // Clear is applied first so an accept in the clear cycle still counts.
    for (int i = 0; i < NUM_STATS; i++) begin
      cnt_d[i] = clear_stats_i ? '0 : cnt_q[i];
      if (hit[i]) cnt_d[i] = sat_inc(cnt_d[i]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_STATS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STATS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt_init_o   = cnt_q[STAT_INIT];
  assign cnt_search_o = cnt_q[STAT_SEARCH];
  assign cnt_insert_o = cnt_q[STAT_INSERT];
  assign cnt_delete_o = cnt_q[STAT_DELETE];
  assign cnt_fail_o   = cnt_q[STAT_FAIL];

`else

  // Statistics not built: outputs are constant and the clear input is inert.
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats_i;

  assign cnt_init_o   = '0;
  assign cnt_search_o = '0;
  assign cnt_insert_o = '0;
  assign cnt_delete_o = '0;
  assign cnt_fail_o   = '0;

`endif

endmodule

// File: tb/tb_ht_res_sink.sv
module tb_ht_res_sink;
  import ht_res_sink_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

`ifdef HT_RES_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rd_en = 1'b0;
  logic           clear = 1'b0;
  logic           rd_valid;
  ht_result_t     rd_data;
  logic [4:0]     used;
  logic [CW-1:0]  c_init, c_search, c_insert, c_delete, c_fail;

  ht_res_if res_if();

  ht_res_sink #(
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .ht_res_in     (res_if),
    .rd_en_i       (rd_en),
    .rd_valid_o    (rd_valid),
    .rd_data_o     (rd_data),
    .used_o        (used),
    .clear_stats_i (clear),
    .cnt_init_o    (c_init),
    .cnt_search_o  (c_search),
    .cnt_insert_o  (c_insert),
    .cnt_delete_o  (c_delete),
    .cnt_fail_o    (c_fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of buffered results and per-counter values
  // (index 0..3 = opcode value, 4 = fail).
  ht_result_t mq[$];
  int         mcnt[5];

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  function automatic ht_result_t mk(input ht_opcode_t op, input ht_rescode_t rc, input int k);
    ht_result_t r;
    r.cmd.opcode = op;
    r.cmd.key    = k[15:0];
    r.cmd.value  = 16'(k * 3 + 7);
    r.rescode    = rc;
    return r;
  endfunction

  function automatic ht_rescode_t ok_rc(input ht_opcode_t op);
    case (op)
      OP_INIT:   return INIT_SUCCESS;
      OP_SEARCH: return SEARCH_FOUND;
      OP_INSERT: return INSERT_SUCCESS;
      default:   return DELETE_SUCCESS;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check_val({tag, ".used"},  64'(used), 64'(mq.size()));
    check_val({tag, ".valid"}, 64'(rd_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) check_val({tag, ".data"}, 64'(rd_data), 64'(mq[0]));
    check_val({tag, ".c_init"},   64'(c_init),   exp_cnt(mcnt[0]));
    check_val({tag, ".c_search"}, 64'(c_search), exp_cnt(mcnt[1]));
    check_val({tag, ".c_insert"}, 64'(c_insert), exp_cnt(mcnt[2]));
    check_val({tag, ".c_delete"}, 64'(c_delete), exp_cnt(mcnt[3]));
    check_val({tag, ".c_fail"},   64'(c_fail),   exp_cnt(mcnt[4]));
  endtask

  // One clock of stimulus: drive, check ready, advance model, clock, check.
  task automatic cycle(input string tag, input bit v, input ht_result_t d, input bit re, input bit clr);
    bit acc, pop, fail;
    res_if.valid  = v;
    res_if.result = d;
    rd_en         = re;
    clear         = clr;
    check_val({tag, ".ready"}, 64'(res_if.ready), 64'(mq.size() < DEPTH));
    acc  = v && (mq.size() < DEPTH);
    pop  = re && (mq.size() != 0);
    fail = (d.rescode == SEARCH_NOT_SUCCESS_NO_ENTRY) ||
           (d.rescode == INSERT_NOT_SUCCESS_TABLE_IS_FULL) ||
           (d.rescode == DELETE_NOT_SUCCESS_NO_ENTRY);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(d);
    if (clr) for (int i = 0; i < 5; i++) mcnt[i] = 0;
    if (acc) begin
      if (mcnt[int'(d.cmd.opcode)] < CMAX) mcnt[int'(d.cmd.opcode)]++;
      if (fail && mcnt[4] < CMAX) mcnt[4]++;
    end
    tick();
    res_if.valid = 1'b0;
    rd_en        = 1'b0;
    clear        = 1'b0;
    check_model(tag);
  endtask

  task automatic check_all_cnt(input string tag, input int i0, input int s, input int ins, input int d, input int f);
    check_val({tag, ".c_init"},   64'(c_init),   exp_cnt(i0));
    check_val({tag, ".c_search"}, 64'(c_search), exp_cnt(s));
    check_val({tag, ".c_insert"}, 64'(c_insert), exp_cnt(ins));
    check_val({tag, ".c_delete"}, 64'(c_delete), exp_cnt(d));
    check_val({tag, ".c_fail"},   64'(c_fail),   exp_cnt(f));
  endtask

  ht_result_t r0, r1, r2, x17, nil;

  initial begin
    nil = '0;
    res_if.valid  = 1'b0;
    res_if.result = '0;
    for (int i = 0; i < 5; i++) mcnt[i] = 0;

    // ---- reset state ----
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.used",  64'(used), 64'd0);
    check_val("rst.valid", 64'(rd_valid), 64'd0);
    check_val("rst.ready", 64'(res_if.ready), 64'd0);
    check_all_cnt("rst", 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    check_val("rel.ready", 64'(res_if.ready), 64'd1);
    check_val("rel.used",  64'(used), 64'd0);

    // ---- three results, no reads ----
    r0 = mk(OP_SEARCH, SEARCH_FOUND,   1);
    r1 = mk(OP_INSERT, INSERT_SUCCESS, 2);
    r2 = mk(OP_DELETE, DELETE_SUCCESS, 3);
    res_if.valid  = 1'b1;
    res_if.result = r0;
    #1;
    check_val("nofall.valid", 64'(rd_valid), 64'd0);
    cycle("p0", 1'b1, r0, 1'b0, 1'b0);
    check_val("lat1.valid", 64'(rd_valid), 64'd1);
    check_val("lat1.data",  64'(rd_data), 64'(r0));
    cycle("p1", 1'b1, r1, 1'b0, 1'b0);
    cycle("p2", 1'b1, r2, 1'b0, 1'b0);
    check_val("three.used",  64'(used), 64'd3);
    check_val("three.valid", 64'(rd_valid), 64'd1);
    check_val("three.data",  64'(rd_data), 64'(r0));
    check_all_cnt("three", 0, 1, 1, 1, 0);
    repeat (3) cycle("drain3", 1'b0, nil, 1'b1, 1'b0);
    cycle("empty_rd", 1'b0, nil, 1'b1, 1'b0);

    // ---- fill to full across the pointer wrap ----
    cycle("clr1", 1'b0, nil, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      cycle("fill", 1'b1, mk(ht_opcode_t'(2'(i)), ok_rc(ht_opcode_t'(2'(i))), 100 + i), 1'b0, 1'b0);
    check_val("full.used",  64'(used), 64'd16);
    check_val("full.ready", 64'(res_if.ready), 64'd0);
    check_val("full.data",  64'(rd_data), 64'(mk(OP_INIT, INIT_SUCCESS, 100)));
    x17 = mk(OP_SEARCH, SEARCH_FOUND, 200);
    cycle("held", 1'b1, x17, 1'b0, 1'b0);
    check_val("held.used", 64'(used), 64'd16);
    cycle("full_pop", 1'b1, x17, 1'b1, 1'b0);
    check_val("afterpop.used",  64'(used), 64'd15);
    check_val("afterpop.ready", 64'(res_if.ready), 64'd1);
    cycle("x17", 1'b1, x17, 1'b0, 1'b0);
    repeat (16) cycle("drain16", 1'b0, nil, 1'b1, 1'b0);
    check_val("drain16.used", 64'(used), 64'd0);

    // ---- streaming: simultaneous accept and pop ----
    cycle("s0", 1'b1, mk(OP_SEARCH, SEARCH_FOUND, 300), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++)
      cycle("stream", 1'b1, mk(OP_SEARCH, SEARCH_FOUND, 301 + i), 1'b1, 1'b0);
    check_val("stream.used", 64'(used), 64'd1);
    check_val("stream.data", 64'(rd_data), 64'(mk(OP_SEARCH, SEARCH_FOUND, 400)));
    cycle("drain1", 1'b0, nil, 1'b1, 1'b0);

    // ---- fail counting and clear-with-accept ----
    cycle("clr2", 1'b0, nil, 1'b0, 1'b1);
    cycle("f_ins", 1'b1, mk(OP_INSERT, INSERT_NOT_SUCCESS_TABLE_IS_FULL, 5), 1'b0, 1'b0);
    cycle("f_del", 1'b1, mk(OP_DELETE, DELETE_NOT_SUCCESS_NO_ENTRY, 6), 1'b0, 1'b0);
    cycle("ok_srch", 1'b1, mk(OP_SEARCH, SEARCH_FOUND, 7), 1'b0, 1'b0);
    check_all_cnt("fails", 0, 1, 1, 1, 2);
    cycle("clr_acc", 1'b1, mk(OP_SEARCH, SEARCH_FOUND, 8), 1'b0, 1'b1);
    check_all_cnt("clr_acc", 0, 1, 0, 0, 0);
    repeat (4) cycle("drain4", 1'b0, nil, 1'b1, 1'b0);

    // ---- saturation at CNT_WIDTH=4 ----
    cycle("clr3", 1'b0, nil, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle("init20", 1'b1, mk(OP_INIT, INIT_SUCCESS, 500 + i), 1'b1, 1'b0);
      if (i == 13) check_val("init14", 64'(c_init), exp_cnt(14));
    end
    check_val("sat.c_init", 64'(c_init), exp_cnt(15));
    cycle("drain_sat", 1'b0, nil, 1'b1, 1'b0);

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 5; i++)
      cycle("pre_rst", 1'b1, mk(OP_INSERT, INSERT_SUCCESS, 600 + i), 1'b0, 1'b0);
    check_val("pre_rst.used", 64'(used), 64'd5);
    res_if.valid  = 1'b1;
    res_if.result = mk(OP_DELETE, DELETE_SUCCESS, 700);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst.used",  64'(used), 64'd0);
    check_val("arst.valid", 64'(rd_valid), 64'd0);
    check_val("arst.ready", 64'(res_if.ready), 64'd0);
    check_all_cnt("arst", 0, 0, 0, 0, 0);
    mq.delete();
    for (int i = 0; i < 5; i++) mcnt[i] = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_val("rel2.used",  64'(used), 64'd0);
    check_val("rel2.ready", 64'(res_if.ready), 64'd1);
    check_val("rel2.valid", 64'(rd_valid), 64'd0);
    cycle("post_rst", 1'b0, nil, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ht_res_sink.md
HT_RES_SINK -- requirements
Module: ht_res_sink

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, result buffer depth in entries (power of 2, at least 2).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each statistics counter.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port ht_res_in, ht_res_if slave modport, -, hash-table result stream: valid, result (ht_result_t), ready.
REQ-006 SHALL have port rd_en_i, input, 1, pop request from the downstream reader.
REQ-007 SHALL have port rd_valid_o, output, 1, head entry valid (FIFO not empty).
REQ-008 SHALL have port rd_data_o, output, ht_result_t, head entry, show-ahead.
REQ-009 SHALL have port used_o, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-010 SHALL have port clear_stats_i, input, 1, synchronous clear of all counters.
REQ-011 SHALL have ports cnt_init_o, cnt_search_o, cnt_insert_o and cnt_delete_o, each output, CNT_WIDTH, accepted results per opcode.
REQ-012 SHALL have port cnt_fail_o, output, CNT_WIDTH, accepted results whose rescode is a not-success code.

Function
REQ-013 ht_res_in.ready SHALL be 1 exactly when used_o < FIFO_DEPTH; accept means valid && ready on a rising edge.
REQ-014 An accepted result SHALL be visible on rd_data_o with rd_valid_o=1 on the next cycle when the FIFO was empty (1-cycle latency, no fall-through).
REQ-015 A pop SHALL occur when rd_en_i && rd_valid_o; rd_en_i while empty SHALL be ignored, with no state change.
REQ-016 Simultaneous accept and pop SHALL leave used_o unchanged and preserve FIFO order.
REQ-017 When full, ready=0 SHALL hold even if rd_en_i=1 in that cycle (ready is a function of registered occupancy only).
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH; used_o SHALL range 0..FIFO_DEPTH.
REQ-019 Each accept SHALL increment the counter selected by result.cmd.opcode, and cnt_fail_o SHALL also increment when result.rescode is in the package not-success set.
REQ-020 Counters SHALL saturate at all-ones and never wrap.
REQ-021 clear_stats_i SHALL zero all counters; an accept in the same cycle SHALL then count, so the affected counters read 1.
REQ-022 Counters SHALL be registered and update the cycle after the accept.
REQ-023 rd_data_o SHALL be don't-care while rd_valid_o=0; the bench SHALL not check it in that state.

Reset
REQ-024 Asserting rst_n_i low SHALL immediately drive used_o=0, rd_valid_o=0, ready=0 and all counters=0, and set both pointers to 0.
REQ-025 After deassertion, ready SHALL go to 1 on the first rising edge, and results in flight at reset SHALL be discarded.

Configuration
REQ-026 With macro HT_RES_SINK_STATS_EN defined, the counter logic of REQ-019..REQ-022 SHALL be present.
REQ-027 Without HT_RES_SINK_STATS_EN, all cnt_*_o SHALL be constant 0, clear_stats_i SHALL be ignored, and no counter flops SHALL be built.

Structure
REQ-028 The hash_table package SHALL hold the not-success rescode set as a function is_fail_rescode(ht_rescode_t) and the statistics counter typedef.
REQ-029 The FIFO storage SHALL be one sub-module, ht_res_sink_fifo (depth-parameterized, show-ahead); the counters SHALL live in the top module.

Verification
REQ-030 Reset, then 3 accepted results (SEARCH, INSERT, DELETE) with rd_en_i=0 -> used_o=3, rd_valid_o=1, rd_data_o equals the first result, cnt_search_o=cnt_insert_o=cnt_delete_o=1.
REQ-031 Push 16 results with FIFO_DEPTH=16 and no reads -> ready=0 on the cycle after the 16th accept; a 17th valid is held off; one pop -> ready=1 next cycle, and order is preserved across the pointer wrap.
REQ-032 Continuous valid=1 and rd_en_i=1 for 100 cycles from 1 entry -> used_o stays 1, and 100 results come out in order.
REQ-033 INSERT with rescode INSERT_NOT_SUCCESS_TABLE_IS_FULL plus DELETE with DELETE_NOT_SUCCESS_NO_ENTRY -> cnt_fail_o=2; clear_stats_i in the same cycle as a SEARCH accept -> cnt_search_o=1, all others 0.
REQ-034 With CNT_WIDTH=4, accept 20 INIT results -> cnt_init_o=15 (saturated); without HT_RES_SINK_STATS_EN -> all counters 0.
REQ-035 Drive rst_n_i low mid-stream with used_o=5 -> outputs reach reset values before the next clock edge, and after release used_o=0 and ready=1.
